// File: rtl/mvm_result_drain.sv
// Buffers parallel lane-result batches from the MVM engine and serializes them
// one lane per beat onto a valid/ready stream, flagging batches lost to overflow.
module mvm_result_drain #(
  parameter int OWIDTH      = 32,
  parameter int NUM_OLANES  = 8,
  parameter int BATCH_DEPTH = 4,
  parameter int LANEW       = $clog2(NUM_OLANES),
  parameter int CNTW        = $clog2(BATCH_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [OWIDTH-1:0] i_result [0:NUM_OLANES-1],
  output logic [OWIDTH-1:0] o_tdata,
  output logic              o_tvalid,
  input  logic              i_tready,
  output logic              o_tlast,
  output logic [LANEW-1:0]  o_tlane,
  output logic [CNTW-1:0]   o_count,
  output logic              o_full,
  output logic              o_overflow,
  input  logic              i_clr_ovf
);

  localparam int PTRW = $clog2(BATCH_DEPTH);
  localparam logic [LANEW-1:0] LAST_LANE = LANEW'(NUM_OLANES - 1);
  localparam logic [PTRW-1:0]  LAST_PTR  = PTRW'(BATCH_DEPTH - 1);
  localparam logic [CNTW-1:0]  DEPTH_C   = CNTW'(BATCH_DEPTH);

  logic [OWIDTH-1:0] mem_q [0:BATCH_DEPTH-1][0:NUM_OLANES-1];

  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [LANEW-1:0] lane_q, lane_d;
  logic             ovf_q, ovf_d;

  logic beat, pop, push, drop;

  always_comb begin
    beat     = o_tvalid & i_tready;
    pop      = beat & (lane_q == LAST_LANE);
    // A full FIFO still accepts a batch when its head batch frees up this cycle.
    push     = i_valid & ((count_q < DEPTH_C) | pop);
    drop     = i_valid & ~push;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    lane_d   = lane_q;
    ovf_d    = ovf_q;

    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTRW'(1);
    end

    if (pop) begin
      lane_d   = '0;
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTRW'(1);
    end else if (beat) begin
      lane_d = lane_q + LANEW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase

    if (drop) begin
      ovf_d = 1'b1;
    end else if (i_clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      lane_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      lane_q   <= lane_d;
      ovf_q    <= ovf_d;
    end
  end

  // Batch storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < NUM_OLANES; i++) begin
        mem_q[wr_ptr_q][i] <= i_result[i];
      end
    end
  end

  assign o_tvalid   = (count_q != '0);
  assign o_tdata    = o_tvalid ? mem_q[rd_ptr_q][lane_q] : '0;
  assign o_tlane    = lane_q;
  assign o_tlast    = o_tvalid & (lane_q == LAST_LANE);
  assign o_count    = count_q;
  assign o_full     = (count_q == DEPTH_C);
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_mvm_result_drain.sv
// Self-checking bench for mvm_result_drain: directed scenarios plus random
// traffic, compared each cycle against a batch-queue reference model.
module tb_mvm_result_drain;

  localparam int OW = 32;
  localparam int NL = 8;
  localparam int BD = 4;

  logic          clk;
  logic          rst;
  logic          i_valid;
  logic [OW-1:0] i_result [0:NL-1];
  logic [OW-1:0] o_tdata;
  logic          o_tvalid;
  logic          i_tready;
  logic          o_tlast;
  logic [2:0]    o_tlane;
  logic [2:0]    o_count;
  logic          o_full;
  logic          o_overflow;
  logic          i_clr_ovf;

  mvm_result_drain #(
    .OWIDTH(OW), .NUM_OLANES(NL), .BATCH_DEPTH(BD)
  ) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_result(i_result),
    .o_tdata(o_tdata), .o_tvalid(o_tvalid), .i_tready(i_tready),
    .o_tlast(o_tlast), .o_tlane(o_tlane), .o_count(o_count),
    .o_full(o_full), .o_overflow(o_overflow), .i_clr_ovf(i_clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: a queue of whole batches, the lane being offered, and the flag.
  logic [NL*OW-1:0] fifo_m [$];
  int               m_lane = 0;
  bit               m_ovf  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [NL*OW-1:0] head;
    logic [OW-1:0]    ed;
    bit               ev;
    ev = (fifo_m.size() != 0);
    ed = '0;
    if (ev) begin
      head = fifo_m[0];
      ed   = head[m_lane*OW +: OW];
    end
    chk("tvalid",   64'(o_tvalid),   64'(ev));
    chk("tdata",    64'(o_tdata),    64'(ed));
    chk("tlane",    64'(o_tlane),    64'(m_lane));
    chk("tlast",    64'(o_tlast),    64'(ev && m_lane == NL-1));
    chk("count",    64'(o_count),    64'(fifo_m.size()));
    chk("full",     64'(o_full),     64'(fifo_m.size() == BD));
    chk("overflow", 64'(o_overflow), 64'(m_ovf));
  endtask

  function automatic logic [NL*OW-1:0] mk(input int base, input int step);
    logic [NL*OW-1:0] r;
    for (int i = 0; i < NL; i++) r[i*OW +: OW] = OW'(base + i*step);
    return r;
  endfunction

  function automatic logic [NL*OW-1:0] rnd_batch();
    logic [NL*OW-1:0] r;
    for (int i = 0; i < NL; i++) r[i*OW +: OW] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    fifo_m.delete();
    m_lane = 0;
    m_ovf  = 1'b0;
  endtask

  // Drive one clock cycle of inputs, advance the model across the edge, then check.
  task automatic cycle(input bit v, input logic [NL*OW-1:0] b, input bit rdy, input bit clr);
    bit ev, beat, pop, acc;
    i_valid   = v;
    i_tready  = rdy;
    i_clr_ovf = clr;
    for (int i = 0; i < NL; i++) i_result[i] = b[i*OW +: OW];
    ev   = (fifo_m.size() != 0);
    beat = ev && rdy;
    pop  = beat && (m_lane == NL-1);
    acc  = v && ((fifo_m.size() < BD) || pop);
    @(posedge clk);
    if (pop) begin
      void'(fifo_m.pop_front());
      m_lane = 0;
    end else if (beat) begin
      m_lane++;
    end
    if (acc) fifo_m.push_back(b);
    if (v && !acc) m_ovf = 1'b1;
    else if (clr)  m_ovf = 1'b0;
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) cycle(1'b0, '0, rdy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_tready = 1'b0; i_clr_ovf = 1'b0;
    for (int i = 0; i < NL; i++) i_result[i] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;

    // Single batch 1..8 streamed with ready held high.
    cycle(1'b1, mk(1, 1), 1'b1, 1'b0);
    idle(9, 1'b1);

    // Backpressure with ready toggling.
    cycle(1'b1, mk(10, 10), 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, (i % 2) == 0, 1'b0);
    idle(2, 1'b1);

    // Overflow: A..D fill the FIFO, E is dropped.
    for (int k = 0; k < 4; k++) cycle(1'b1, mk(100*(k+1), 1), 1'b0, 1'b0);
    chk("full_after_D", 64'(o_full), 64'd1);
    cycle(1'b1, mk(500, 1), 1'b0, 1'b0);
    chk("ovf_after_E", 64'(o_overflow), 64'd1);
    idle(34, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);

    // Full FIFO with a push landing on the head batch's last-lane beat.
    for (int k = 0; k < 4; k++) cycle(1'b1, mk(1000*(k+1), 3), 1'b0, 1'b0);
    idle(7, 1'b1);
    cycle(1'b1, mk(7000, 5), 1'b1, 1'b0);
    chk("full_pop_count", 64'(o_count), 64'd4);
    chk("full_pop_ovf", 64'(o_overflow), 64'd0);
    idle(34, 1'b1);

    // Overflow clear, then a drop coinciding with the clear.
    for (int k = 0; k < 4; k++) cycle(1'b1, mk(20*k, 2), 1'b0, 1'b0);
    cycle(1'b1, mk(900, 1), 1'b0, 1'b0);
    chk("ovf_set", 64'(o_overflow), 64'd1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("ovf_cleared", 64'(o_overflow), 64'd0);
    cycle(1'b1, mk(950, 1), 1'b0, 1'b1);
    chk("ovf_set_wins", 64'(o_overflow), 64'd1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    idle(34, 1'b1);

    // Asynchronous reset while lane 3 is on the stream.
    cycle(1'b1, mk(40, 1), 1'b1, 1'b0);
    idle(3, 1'b1);
    chk("pre_rst_lane", 64'(o_tlane), 64'd3);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst_tvalid", 64'(o_tvalid), 64'd0);
    check_outputs();
    @(posedge clk);
    #1 rst = 1'b0;
    cycle(1'b1, mk(9, 1), 1'b1, 1'b0);
    idle(9, 1'b1);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 99) < 35, rnd_batch(),
            $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 5);
    end
    idle(40, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
